// File: rtl/ones_csum_pkg.sv
// ones_csum_pkg: shared FSM encoding and all-ones constant for the ones'-complement checksum checker.
package ones_csum_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, FOLD, DONE} state_t;

    function automatic logic [63:0] all_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/ones_add.sv
// ones_add: combinational ones'-complement adder with end-around carry.
module ones_add #(
    parameter int BUS_WIDTH = 8
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    output logic [BUS_WIDTH-1:0] y
);
    logic [BUS_WIDTH:0] s;

    assign s = {1'b0, a} + {1'b0, b};
    // Adding the carry back into a sum of two W-bit values cannot overflow again.
    assign y = s[BUS_WIDTH-1:0] + {{(BUS_WIDTH-1){1'b0}}, s[BUS_WIDTH]};
endmodule

// File: rtl/ones_csum_check.sv
// ones_csum_check: streams a frame, verifies its ones'-complement sum is all-ones.
// Define ONES_CSUM_ERR_CNT_EN to enable the saturating failed-frame counter.
module ones_csum_check
    import ones_csum_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 busy,
    output logic                 done,
    output logic                 csum_ok,
    output logic [BUS_WIDTH-1:0] sum_out,
    output logic [7:0]           err_cnt
);
    localparam logic [BUS_WIDTH-1:0] ONES = BUS_WIDTH'(all_ones(BUS_WIDTH));

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d, acc_sum;
    logic                 ok_q, ok_d;

    ones_add #(.BUS_WIDTH(BUS_WIDTH)) u_add (
        .a(acc_q),
        .b(in_data),
        .y(acc_sum)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ok_d    = ok_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                acc_d   = '0;
            end
            ACCUM: if (in_valid) begin
                acc_d   = acc_sum;
                state_d = in_last ? FOLD : ACCUM;
            end
            FOLD: begin
                ok_d    = (acc_q == ONES);
                sum_d   = ~acc_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ok_q    <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ok_q    <= ok_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready = (state_q == ACCUM);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign csum_ok  = ok_q;
    assign sum_out  = sum_q;

`ifdef ONES_CSUM_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = (state_q == FOLD && acc_q != ONES && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_ones_csum_check.sv
// tb_ones_csum_check: directed scoreboard bench for ones_csum_check (BUS_WIDTH=8).
module tb_ones_csum_check;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, busy, done, csum_ok;
    logic [W-1:0] sum_out;
    logic [7:0]   err_cnt;

    ones_csum_check #(.BUS_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .busy(busy), .done(done),
        .csum_ok(csum_ok), .sum_out(sum_out), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ok;
        logic [7:0] sum;
        logic [7:0] err;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, passed = 0, fails = 0;
    int         last_cyc = 0;
    logic [7:0] exp_err = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        int  n = 0;
        bit  got = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!got && n < 20) begin
            got = in_ready;
            if (got) last_cyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        if (!got) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("latency", cyc - last_cyc, 2);
            chk("csum_ok", csum_ok, e.ok);
            chk("sum_out", sum_out, e.sum);
            chk("err_cnt", err_cnt, e.err);
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("idle_after", busy, 0);
            chk("hold_ok", csum_ok, e.ok);
            chk("hold_sum", sum_out, e.sum);
        end
    endtask

    // gap: when set, insert 1-3 idle cycles between words; poke: pulse start during gaps.
    task automatic run_frame(input logic [7:0] w[4], input int n, input bit gap, input bit poke,
                             input logic ok, input logic [7:0] sum);
`ifdef ONES_CSUM_ERR_CNT_EN
        if (!ok) exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
`endif
        sb.push_back('{ok, sum, exp_err});
        start_frame();
        for (int i = 0; i < n; i++) begin
            send_word(w[i], i == n - 1);
            if (gap && i < n - 1) begin
                repeat ((i % 3) + 1) begin
                    if (poke) start = 1'b1;
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
        end
        wait_done();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_ok", csum_ok, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_err", err_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame('{8'h12, 8'h34, 8'hB9, 8'h00}, 3, 0, 0, 1'b1, 8'h00);
        run_frame('{8'hF0, 8'h20, 8'hEE, 8'h00}, 3, 0, 0, 1'b1, 8'h00);
        run_frame('{8'h12, 8'h34, 8'hB8, 8'h00}, 3, 0, 0, 1'b0, 8'h01);
        run_frame('{8'h12, 8'h34, 8'hB9, 8'h00}, 3, 1, 1, 1'b1, 8'h00);
        run_frame('{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 1'b1, 8'h00);

        start_frame();
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        rst = 1'b1;
        exp_err = 8'd0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ok", csum_ok, 0);
        chk("mid_rst_sum", sum_out, 0);
        chk("mid_rst_err", err_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
        end
        @(posedge clk); #1;
        run_frame('{8'h12, 8'h34, 8'hB9, 8'h00}, 3, 0, 0, 1'b1, 8'h00);

`ifdef ONES_CSUM_ERR_CNT_EN
        repeat (256) run_frame('{8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 1'b0, 8'hFF);
        chk("err_sat", err_cnt, 255);
`else
        repeat (3) run_frame('{8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 1'b0, 8'hFF);
        chk("err_tied", err_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ones_csum_check.md
ONES_CSUM_CHECK -- requirements
Module: ones_csum_check

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begins a frame when sampled high in IDLE.
REQ-005 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port in_data  input  BUS_WIDTH  frame word, checksum word included.
REQ-008 SHALL have port in_last  input  1  marks final word of frame.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port csum_ok  output  1  frame ones'-complement sum equals all-ones.
REQ-012 SHALL have port sum_out  output  BUS_WIDTH  inverted final sum (zero when ok).
REQ-013 SHALL have port err_cnt  output  8  failed-frame count.

Function
REQ-014 SHALL implement states IDLE, ACCUM, FOLD, DONE.
REQ-015 SHALL transition IDLE->ACCUM on start, clearing accumulator to 0; start outside IDLE ignored.
REQ-016 SHALL drive in_ready=1 only in ACCUM; word accepted on in_valid&in_ready.
REQ-017 SHALL update accumulator per accepted word: s = acc + in_data (BUS_WIDTH+1 bits); acc = s[BUS_WIDTH-1:0] + s[BUS_WIDTH], single cycle, no second overflow possible.
REQ-018 SHALL hold accumulator when in_valid low in ACCUM; no frame-length limit.
REQ-019 SHALL go ACCUM->FOLD on an accepted word with in_last=1; a single-word frame is legal.
REQ-020 SHALL in FOLD register csum_ok = (acc == all-ones) and sum_out = ~acc; a frame summing to all-zeros is an error.
REQ-021 SHALL in DONE assert done for exactly one cycle, then return to IDLE.
REQ-022 SHALL give latency: last word accepted cycle N, done high cycle N+2, IDLE at N+3.
REQ-023 SHALL hold csum_ok and sum_out stable from DONE until the next FOLD.

Reset
REQ-024 SHALL on rst, at any time including mid-frame: state IDLE, accumulator 0, in_ready 0, busy 0, done 0, csum_ok 0, sum_out 0, err_cnt 0.
REQ-025 SHALL discard a partially accumulated frame on reset; no done pulse for it.

Configuration
REQ-026 SHALL with macro ONES_CSUM_ERR_CNT_EN defined increment err_cnt in FOLD when csum_ok computes 0, saturating at 255.
REQ-027 SHALL without ONES_CSUM_ERR_CNT_EN keep the err_cnt port, tied to constant 0, with no counter logic.

Structure
REQ-028 SHALL place state encoding and an all-ones constant function of BUS_WIDTH in shared package ones_csum_pkg.
REQ-029 SHALL implement end-around-carry addition in sub-module ones_add (combinational, BUS_WIDTH parameter); all state lives in ones_csum_check.

Verification (BUS_WIDTH=8)
REQ-030 SHALL cover: start; words 0x12, 0x34, 0xB9 (last), back-to-back -> done at N+2, csum_ok=1, sum_out=0x00, err_cnt=0.
REQ-031 SHALL cover end-around carry: 0xF0, 0x20 (acc 0x11), 0xEE last -> csum_ok=1, sum_out=0x00.
REQ-032 SHALL cover corruption: 0x12, 0x34, 0xB8 last -> csum_ok=0, sum_out=0x01, err_cnt=1 (macro on) / 0 (macro off).
REQ-033 SHALL cover in_valid gaps of 1-3 cycles between words of REQ-030 frame and start pulsed while busy -> identical result, start ignored.
REQ-034 SHALL cover rst pulsed after second word of a frame -> all outputs 0 next cycle, no done; following REQ-030 frame passes.
REQ-035 SHALL cover 256 consecutive failing frames with macro on -> err_cnt stops at 255.
